// File: rtl/reg_gpr_banked_n_if.sv
// reg_gpr_banked_n_if: register file bus grouping read, write, load-issue and load-return signals.
// Ports (master drives / slave receives):
//   bank_sel                 bank used for reads, port-0 writes and load issue
//   rs/rt/rn_id -> _val      three combinational read ports
//   wr0_id, wr0_val, ex_hold execute write port and pipeline hold
//   ld_issue, ld_id -> ld_tag  load issue and its physical tag
//   wr1_en, wr1_tag, wr1_val load-return write port addressed by tag
//   stall                    read of a register with an outstanding load
interface reg_gpr_banked_n_if #(
    parameter int XLEN   = 32,
    parameter int NBANKS = 2
);
    localparam int BW = NBANKS > 1 ? $clog2(NBANKS) : 1;
    localparam int TW = $clog2(NBANKS * 16);
    logic [BW-1:0]   bank_sel;
    logic [6:0]      rs_id, rt_id, rn_id;
    logic [XLEN-1:0] rs_val, rt_val, rn_val;
    logic [6:0]      wr0_id;
    logic [XLEN-1:0] wr0_val;
    logic            ex_hold;
    logic            ld_issue;
    logic [6:0]      ld_id;
    logic [TW-1:0]   ld_tag;
    logic            wr1_en;
    logic [TW-1:0]   wr1_tag;
    logic [XLEN-1:0] wr1_val;
    logic            stall;
    modport master (
        output bank_sel, rs_id, rt_id, rn_id, wr0_id, wr0_val, ex_hold,
               ld_issue, ld_id, wr1_en, wr1_tag, wr1_val,
        input  rs_val, rt_val, rn_val, ld_tag, stall
    );
    modport slave (
        input  bank_sel, rs_id, rt_id, rn_id, wr0_id, wr0_val, ex_hold,
               ld_issue, ld_id, wr1_en, wr1_tag, wr1_val,
        output rs_val, rt_val, rn_val, ld_tag, stall
    );
endinterface

// File: rtl/reg_gpr_banked_n.sv
// reg_gpr_banked_n: 16-entry GPR file with banked low registers, write bypass and load scoreboard.
// Ports:
//   clock, reset  clock and synchronous active-high reset
//   bus           reg_gpr_banked_n_if slave: reads, wr0/wr1 writes, load issue, stall
module reg_gpr_banked_n #(
    parameter int XLEN    = 32,
    parameter int NBANKS  = 2,
    parameter int NBANKED = 8
) (
    input logic               clock,
    input logic               reset,
    reg_gpr_banked_n_if.slave bus
);
    localparam int NT = NBANKS * 16;
    localparam int TW = $clog2(NT);
    localparam int BW = NBANKS > 1 ? $clog2(NBANKS) : 1;

    logic [XLEN-1:0] regs_q [NT];
    logic [XLEN-1:0] regs_d [NT];
    logic [NT-1:0]   pend_q, pend_d;
    // Tag was overwritten by wr0 while its load was outstanding; the late return is dropped.
    logic [NT-1:0]   sq_q, sq_d;
    logic            wr0_en, wr1_ok, ld_en, stall_c;
    logic [TW-1:0]   wr0_t, ld_t;
    logic [6:0]      rid [3];
    logic [TW-1:0]   rtag [3];
    logic [XLEN-1:0] rv [3];

    function automatic logic [TW-1:0] tag_of(input logic [6:0] id, input logic [BW-1:0] bs);
        logic [BW-1:0] bk;
        bk = (32'(id[3:0]) < NBANKED) ? bs : '0;
        return TW'({bk, id[3:0]});
    endfunction

    function automatic logic id_ok(input logic [6:0] id);
        return id[6:4] == 3'd0;
    endfunction

    assign rid[0] = bus.rs_id;
    assign rid[1] = bus.rt_id;
    assign rid[2] = bus.rn_id;
    assign wr0_en = !bus.ex_hold && id_ok(bus.wr0_id);
    assign wr0_t  = tag_of(bus.wr0_id, bus.bank_sel);
    assign wr1_ok = bus.wr1_en && !sq_q[bus.wr1_tag];
    assign ld_en  = bus.ld_issue && !bus.ex_hold && id_ok(bus.ld_id);
    assign ld_t   = tag_of(bus.ld_id, bus.bank_sel);

    always_comb begin
        stall_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rtag[i] = tag_of(rid[i], bus.bank_sel);
            rv[i] = !id_ok(rid[i]) ? '0 :
                    (wr0_en && wr0_t == rtag[i]) ? bus.wr0_val :
                    (wr1_ok && bus.wr1_tag == rtag[i]) ? bus.wr1_val : regs_q[rtag[i]];
            stall_c = stall_c | (id_ok(rid[i]) && pend_q[rtag[i]] &&
                                 !(wr1_ok && bus.wr1_tag == rtag[i]));
        end
    end

    assign bus.rs_val = rv[0];
    assign bus.rt_val = rv[1];
    assign bus.rn_val = rv[2];
    assign bus.stall  = stall_c;
    assign bus.ld_tag = ld_t;

    // Statement order encodes priority: wr0 over wr1 for data, issue over completion for pending.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        sq_d   = sq_q;
        if (bus.wr1_en) sq_d[bus.wr1_tag] = 1'b0;
        if (wr1_ok) begin
            regs_d[bus.wr1_tag] = bus.wr1_val;
            pend_d[bus.wr1_tag] = 1'b0;
        end
        if (wr0_en) begin
            regs_d[wr0_t] = bus.wr0_val;
            if (pend_q[wr0_t] && !(wr1_ok && bus.wr1_tag == wr0_t)) sq_d[wr0_t] = 1'b1;
            pend_d[wr0_t] = 1'b0;
        end
        if (ld_en) pend_d[ld_t] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '{default: '0};
            pend_q <= '0;
            sq_q   <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            sq_q   <= sq_d;
        end
    end
endmodule

// File: tb/tb_reg_gpr_banked_n.sv
// tb_reg_gpr_banked_n: checks the banked register file against a per-bank array model plus directed literals.
module tb_reg_gpr_banked_n;
    localparam int NB = 8;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   run = 1'b0;

    reg_gpr_banked_n_if #(.XLEN(32), .NBANKS(2)) bus0 ();
    reg_gpr_banked_n_if #(.XLEN(64), .NBANKS(4)) bus1 ();

    reg_gpr_banked_n #(.XLEN(32), .NBANKS(2), .NBANKED(8)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    reg_gpr_banked_n #(.XLEN(64), .NBANKS(4), .NBANKED(8)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    always #5 clock = ~clock;

    // Model: each bank sees its own 16 registers; shared ones are kept identical in every bank.
    logic [31:0] mreg [2][16];
    bit          pend [32];
    bit          dead [32];

    function automatic int ptag(input int b, input int id);
        return id < NB ? b * 16 + id : id;
    endfunction
    function automatic bit w0();
        return !bus0.ex_hold && bus0.wr0_id < 16;
    endfunction
    function automatic bit w1();
        return bus0.wr1_en && !dead[bus0.wr1_tag];
    endfunction
    function automatic int t0();
        return ptag(bus0.bank_sel, bus0.wr0_id);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [6:0] id);
        int t;
        if (id >= 16) return 32'd0;
        t = ptag(bus0.bank_sel, id);
        if (w0() && t0() == t) return bus0.wr0_val;
        if (w1() && bus0.wr1_tag == t) return bus0.wr1_val;
        return mreg[bus0.bank_sel][id];
    endfunction

    function automatic bit exp_stall();
        logic [6:0] ids [3];
        int t;
        bit s;
        ids[0] = bus0.rs_id; ids[1] = bus0.rt_id; ids[2] = bus0.rn_id;
        s = 1'b0;
        for (int i = 0; i < 3; i++)
            if (ids[i] < 16) begin
                t = ptag(bus0.bank_sel, ids[i]);
                if (pend[t] && !(w1() && bus0.wr1_tag == t)) s = 1'b1;
            end
        return s;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < 32; t++) begin pend[t] <= 1'b0; dead[t] <= 1'b0; end
            for (int b = 0; b < 2; b++) for (int r = 0; r < 16; r++) mreg[b][r] <= 32'd0;
        end else begin
            if (bus0.wr1_en) dead[bus0.wr1_tag] <= 1'b0;
            if (w1()) begin
                for (int b = 0; b < 2; b++)
                    if (bus0.wr1_tag % 16 >= NB || b == bus0.wr1_tag / 16)
                        mreg[b][bus0.wr1_tag % 16] <= bus0.wr1_val;
                pend[bus0.wr1_tag] <= 1'b0;
            end
            if (w0()) begin
                for (int b = 0; b < 2; b++)
                    if (bus0.wr0_id >= NB || b == bus0.bank_sel)
                        mreg[b][bus0.wr0_id[3:0]] <= bus0.wr0_val;
                if (pend[t0()] && !(w1() && bus0.wr1_tag == t0())) dead[t0()] <= 1'b1;
                pend[t0()] <= 1'b0;
            end
            if (bus0.ld_issue && !bus0.ex_hold && bus0.ld_id < 16)
                pend[ptag(bus0.bank_sel, bus0.ld_id)] <= 1'b1;
        end
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask

    always @(negedge clock) if (run) begin
        chk("m_rs", 64'(bus0.rs_val), 64'(exp_rd(bus0.rs_id)));
        chk("m_rt", 64'(bus0.rt_val), 64'(exp_rd(bus0.rt_id)));
        chk("m_rn", 64'(bus0.rn_val), 64'(exp_rd(bus0.rn_id)));
        chk("m_stall", 64'(bus0.stall), 64'(exp_stall()));
        if (bus0.ld_id < 16) chk("m_ldtag", 64'(bus0.ld_tag), 64'(ptag(bus0.bank_sel, bus0.ld_id)));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle0();
        bus0.rs_id = 7'h7F; bus0.rt_id = 7'h7F; bus0.rn_id = 7'h7F;
        bus0.wr0_id = 7'h7F; bus0.wr0_val = '0; bus0.ex_hold = 1'b0;
        bus0.ld_issue = 1'b0; bus0.ld_id = 7'd0;
        bus0.wr1_en = 1'b0; bus0.wr1_tag = '0; bus0.wr1_val = '0;
    endtask

    task automatic idle1();
        bus1.bank_sel = '0;
        bus1.rs_id = 7'h7F; bus1.rt_id = 7'h7F; bus1.rn_id = 7'h7F;
        bus1.wr0_id = 7'h7F; bus1.wr0_val = '0; bus1.ex_hold = 1'b0;
        bus1.ld_issue = 1'b0; bus1.ld_id = 7'd0;
        bus1.wr1_en = 1'b0; bus1.wr1_tag = '0; bus1.wr1_val = '0;
    endtask

    initial begin
        bus0.bank_sel = 1'b0;
        idle0();
        idle1();
        tick();
        tick();
        reset = 1'b0;
        run = 1'b1;
        bus0.rs_id = 7'd0; bus0.rt_id = 7'd5; bus0.rn_id = 7'd15;
        #2;
        chk("rst_rs", 64'(bus0.rs_val), 64'd0);
        chk("rst_rn", 64'(bus0.rn_val), 64'd0);
        chk("rst_stall", 64'(bus0.stall), 64'd0);
        tick();
        idle0(); bus0.bank_sel = 1'b0; bus0.wr0_id = 7'd3; bus0.wr0_val = 32'h11111111;
        tick();
        idle0(); bus0.bank_sel = 1'b1; bus0.wr0_id = 7'd3; bus0.wr0_val = 32'h22222222;
        tick();
        idle0(); bus0.bank_sel = 1'b0; bus0.rs_id = 7'd3;
        #2 chk("r3_b0", 64'(bus0.rs_val), 64'h11111111);
        bus0.bank_sel = 1'b1;
        #2 chk("r3_b1", 64'(bus0.rs_val), 64'h22222222);
        tick();
        idle0(); bus0.bank_sel = 1'b0; bus0.wr0_id = 7'd9; bus0.wr0_val = 32'h00000099;
        tick();
        idle0(); bus0.bank_sel = 1'b1; bus0.rs_id = 7'd9; bus0.rt_id = 7'h10;
        #2 chk("r9_shared", 64'(bus0.rs_val), 64'h99);
        chk("bad_id", 64'(bus0.rt_val), 64'd0);
        tick();
        idle0(); bus0.bank_sel = 1'b0; bus0.wr0_id = 7'h13; bus0.wr0_val = 32'hFFFFFFFF;
        tick();
        idle0(); bus0.rs_id = 7'd3;
        #2 chk("nowrite_bad", 64'(bus0.rs_val), 64'h11111111);
        tick();
        idle0(); bus0.wr0_id = 7'd5; bus0.wr0_val = 32'hDEADBEEF; bus0.rs_id = 7'd5;
        #2 chk("byp_wr0", 64'(bus0.rs_val), 64'hDEADBEEF);
        tick();
        idle0(); bus0.ex_hold = 1'b1; bus0.wr0_id = 7'd5; bus0.wr0_val = 32'h12345678; bus0.rs_id = 7'd5;
        #2 chk("hold_old", 64'(bus0.rs_val), 64'hDEADBEEF);
        tick();
        idle0(); bus0.rs_id = 7'd5;
        #2 chk("hold_nowr", 64'(bus0.rs_val), 64'hDEADBEEF);
        tick();
        idle0(); bus0.bank_sel = 1'b1; bus0.ld_issue = 1'b1; bus0.ld_id = 7'd2;
        #2 chk("ldtag_12", 64'(bus0.ld_tag), 64'h12);
        tick();
        idle0(); bus0.bank_sel = 1'b0; bus0.rt_id = 7'd2;
        #2 chk("stall_b0", 64'(bus0.stall), 64'd0);
        tick();
        bus0.bank_sel = 1'b1;
        #2 chk("stall_b1", 64'(bus0.stall), 64'd1);
        tick();
        bus0.wr1_en = 1'b1; bus0.wr1_tag = 5'h12; bus0.wr1_val = 32'h55;
        #2 chk("wr1_stall", 64'(bus0.stall), 64'd0);
        chk("wr1_byp", 64'(bus0.rt_val), 64'h55);
        tick();
        idle0(); bus0.bank_sel = 1'b1; bus0.rt_id = 7'd2;
        #2 chk("wr1_done", 64'(bus0.rt_val), 64'h55);
        tick();
        idle0(); bus0.bank_sel = 1'b0; bus0.ld_issue = 1'b1; bus0.ld_id = 7'd8;
        #2 chk("ldtag_08", 64'(bus0.ld_tag), 64'h08);
        tick();
        idle0(); bus0.wr0_id = 7'd8; bus0.wr0_val = 32'h7;
        tick();
        idle0(); bus0.wr1_en = 1'b1; bus0.wr1_tag = 5'h08; bus0.wr1_val = 32'h9; bus0.rs_id = 7'd8;
        #2 chk("waw_byp", 64'(bus0.rs_val), 64'h7);
        chk("waw_stall", 64'(bus0.stall), 64'd0);
        tick();
        idle0(); bus0.rs_id = 7'd8;
        #2 chk("waw_val", 64'(bus0.rs_val), 64'h7);
        tick();
        idle0(); bus0.wr0_id = 7'd10; bus0.wr0_val = 32'hA;
        bus0.wr1_en = 1'b1; bus0.wr1_tag = 5'h0A; bus0.wr1_val = 32'hB; bus0.rs_id = 7'd10;
        tick();
        idle0(); bus0.rs_id = 7'd10;
        #2 chk("coll_r10", 64'(bus0.rs_val), 64'hA);
        tick();
        idle0(); bus0.ld_issue = 1'b1; bus0.ld_id = 7'd4;
        bus0.wr1_en = 1'b1; bus0.wr1_tag = 5'h04; bus0.wr1_val = 32'h44;
        tick();
        idle0(); bus0.rs_id = 7'd4;
        #2 chk("coll_pend", 64'(bus0.stall), 64'd1);
        tick();
        bus0.wr1_en = 1'b1; bus0.wr1_tag = 5'h04; bus0.wr1_val = 32'h45;
        tick();
        idle0(); bus0.rs_id = 7'd4;
        #2 chk("coll_clr", 64'(bus0.stall), 64'd0);
        tick();
        idle0(); bus0.ld_issue = 1'b1; bus0.ld_id = 7'd1;
        tick();
        idle0(); reset = 1'b1;
        bus0.wr0_id = 7'd6; bus0.wr0_val = 32'h66; bus0.ld_issue = 1'b1; bus0.ld_id = 7'd7;
        tick();
        reset = 1'b0;
        idle0(); bus0.rs_id = 7'd1; bus0.rt_id = 7'd3; bus0.rn_id = 7'd6;
        #2 chk("rmid_rs", 64'(bus0.rs_val), 64'd0);
        chk("rmid_rt", 64'(bus0.rt_val), 64'd0);
        chk("rmid_rn", 64'(bus0.rn_val), 64'd0);
        chk("rmid_stall", 64'(bus0.stall), 64'd0);
        tick();
        idle0(); bus0.wr1_en = 1'b1; bus0.wr1_tag = 5'h01; bus0.wr1_val = 32'h77;
        tick();
        idle0(); bus0.rs_id = 7'd1; bus0.rt_id = 7'd7;
        #2 chk("post_wr1", 64'(bus0.rs_val), 64'h77);
        chk("post_stall", 64'(bus0.stall), 64'd0);
        for (int b = 0; b < 4; b++) begin
            tick();
            idle1(); bus1.bank_sel = 2'(b); bus1.wr0_id = 7'd3;
            bus1.wr0_val = 64'h1111111111111111 * 64'(b + 1);
        end
        tick();
        idle1(); bus1.wr0_id = 7'd9; bus1.wr0_val = 64'hCAFE0000F00D0009;
        tick();
        idle1();
        for (int b = 0; b < 4; b++) begin
            bus1.bank_sel = 2'(b); bus1.rs_id = 7'd3; bus1.rt_id = 7'd9;
            #2 chk("x64_r3", bus1.rs_val, 64'h1111111111111111 * 64'(b + 1));
            chk("x64_r9", bus1.rt_val, 64'hCAFE0000F00D0009);
        end
        tick();
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
